iomem_gpio: RTL

IOMEM_GPIO -- requirements
Module: iomem_gpio

---
 rtl/iomem_gpio.sv | 135 +++++++++++++
 1 files changed

// File: rtl/iomem_gpio.sv
// Memory-mapped GPIO block for a PicoRV32-style iomem bus.
// Provides pad output/enable registers, synchronised inputs and edge-triggered interrupts.
module iomem_gpio #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [7:0]  BASE        = 8'h03,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [5:0] OFF_OUT  = 6'd0;
    localparam logic [5:0] OFF_OE   = 6'd1;
    localparam logic [5:0] OFF_IN   = 6'd2;
    localparam logic [5:0] OFF_EN   = 6'd3;
    localparam logic [5:0] OFF_RISE = 6'd4;
    localparam logic [5:0] OFF_FALL = 6'd5;
    localparam logic [5:0] OFF_STAT = 6'd6;

    logic                             r_ready;
    logic [31:0]                      r_rdata;
    logic [WIDTH-1:0]                 r_out;
    logic [WIDTH-1:0]                 r_oe;
    logic [WIDTH-1:0]                 r_en;
    logic [WIDTH-1:0]                 r_rise;
    logic [WIDTH-1:0]                 r_fall;
    logic [WIDTH-1:0]                 r_stat;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                 r_prev;
    logic                             r_irq;

    logic             w_sel;
    logic             w_wr;
    logic [5:0]       w_off;
    logic [31:0]      w_bmask;
    logic [WIDTH-1:0] w_wmask;
    logic [WIDTH-1:0] w_wbits;
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdata;
    logic             w_unused_addr;

    // Byte-strobed merge of write data into a WIDTH-bit register
    function automatic logic [WIDTH-1:0] f_merge(
        input logic [WIDTH-1:0] old,
        input logic [WIDTH-1:0] mask,
        input logic [WIDTH-1:0] bits
    );
        return (old & ~mask) | bits;
    endfunction

    assign w_sel   = iomem_valid && !r_ready && (iomem_addr[31:24] == BASE);
    assign w_wr    = w_sel && (iomem_wstrb != 4'b0000);
    assign w_off   = iomem_addr[7:2];
    assign w_bmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                      {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign w_wmask = WIDTH'(w_bmask);
    assign w_wbits = WIDTH'(iomem_wdata & w_bmask);
    assign w_in    = r_sync[SYNC_STAGES-1];

    assign w_unused_addr = ^{iomem_addr[23:8], iomem_addr[1:0]};

    // Edge events are qualified by the per-bit rise/fall selects, independent of IRQ_EN
    assign w_set = (w_in & ~r_prev & r_rise) | (~w_in & r_prev & r_fall);
    assign w_clr = (w_wr && (w_off == OFF_STAT)) ? w_wbits : '0;

    // Read mux returns pre-write register contents
    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            OFF_OUT:  w_rdata = 32'(r_out);
            OFF_OE:   w_rdata = 32'(r_oe);
            OFF_IN:   w_rdata = 32'(w_in);
            OFF_EN:   w_rdata = 32'(r_en);
            OFF_RISE: w_rdata = 32'(r_rise);
            OFF_FALL: w_rdata = 32'(r_fall);
            OFF_STAT: w_rdata = 32'(r_stat);
            default:  w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
            r_out   <= '0;
            r_oe    <= '0;
            r_en    <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_stat  <= '0;
            r_sync  <= '0;
            r_prev  <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_ready <= w_sel;
            if (w_sel) begin
                r_rdata <= w_rdata;
            end
            if (w_wr) begin
                case (w_off)
                    OFF_OUT:  r_out  <= f_merge(r_out,  w_wmask, w_wbits);
                    OFF_OE:   r_oe   <= f_merge(r_oe,   w_wmask, w_wbits);
                    OFF_EN:   r_en   <= f_merge(r_en,   w_wmask, w_wbits);
                    OFF_RISE: r_rise <= f_merge(r_rise, w_wmask, w_wbits);
                    OFF_FALL: r_fall <= f_merge(r_fall, w_wmask, w_wbits);
                    default:  ;
                endcase
            end
            // New edges override a same-cycle write-1-to-clear
            r_stat <= (r_stat & ~w_clr) | w_set;
            r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_in};
            r_prev <= w_in;
            r_irq  <= |(r_stat & r_en);
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign gpio_out    = r_out;
    assign gpio_oe     = r_oe;
    assign irq         = r_irq;

endmodule
